core_fetch_window: RTL

- Instruction window that sits directly upstream of the cascaded instruction decoders.
- Holds up to DEPTH in-order instructions (slot 0 = oldest) and presents each slot's instruction, PC and valid bit to one decoder of the cascade; slot valid drives the head decoder's cascade enable.
- Refills itself from the shared instruction/data memory port, one request at a time.
- Retires slots the decoders consumed, flushes on jump and stops on halt.

---
 rtl/core_fetch_window_if.sv | 16 +
 rtl/core_fetch_window.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/core_fetch_window_if.sv
// Fetch-side memory port of the instruction window.
// Handshake: the fetcher holds req/addr until a cycle with gnt=1 accepts it;
// exactly one rvalid pulse answers each accepted request, at least one cycle later.
interface core_fetch_window_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/core_fetch_window.sv
// In-order instruction window feeding the decoder cascade; refills one request
// at a time from the shared memory port, retires consumed slots, flushes on jump.
module core_fetch_window #(
  parameter int            DEPTH    = 4,
  parameter int            AW       = 8,
  parameter int            DW       = 16,
  parameter logic [AW-1:0] RESET_PC = 8'h10
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  core_fetch_window_if.master          mem,
  output logic [DEPTH-1:0]             slot_valid_o,
  output logic [DEPTH*DW-1:0]          slot_instr_o,
  output logic [DEPTH*AW-1:0]          slot_pc_o,
  input  logic [$clog2(DEPTH+1)-1:0]   retire_cnt_i,
  input  logic                         jump_en_i,
  input  logic [AW-1:0]                jump_addr_i,
  input  logic                         halt_i,
  output logic                         halted_o,
  output logic [1:0]                   state_o
);
  localparam int            CW      = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2, S_HALTED = 2'd3} state_t;

  state_t          state;
  logic [AW-1:0]   fetch_pc;
  logic [CW-1:0]   count;
  logic [DEPTH-1:0] valid_q;
  logic [DW-1:0]   instr_q [DEPTH];
  logic [AW-1:0]   pc_q    [DEPTH];
  logic            req_q;
  logic [AW-1:0]   addr_q;
  logic            halted_q;

  logic [CW-1:0]    retire_eff, kept, n_count;
  logic             fire, append;
  logic [DEPTH-1:0] n_valid;
  logic [DW-1:0]    n_instr [DEPTH];
  logic [AW-1:0]    n_pc    [DEPTH];

  // Shift survivors down by the retire count, then place an arriving word
  // directly behind them so retire and append combine in one cycle.
  always_comb begin
    retire_eff = (retire_cnt_i > count) ? count : retire_cnt_i;
    kept       = count - retire_eff;
    fire       = (state == S_REQ) && req_q && mem.mem_gnt;
    append     = (state == S_WAIT) && mem.mem_rvalid;
    n_count    = kept + (append ? CW'(1) : CW'(0));
    for (int k = 0; k < DEPTH; k++) begin
      n_valid[k] = 1'b0;
      n_instr[k] = instr_q[k];
      n_pc[k]    = pc_q[k];
      for (int j = 0; j < DEPTH; j++) begin
        if (j == k + int'(retire_eff)) begin
          n_valid[k] = valid_q[j];
          n_instr[k] = instr_q[j];
          n_pc[k]    = pc_q[j];
        end
      end
      if (append && k == int'(kept)) begin
        n_valid[k] = 1'b1;
        n_instr[k] = mem.mem_rdata;
        n_pc[k]    = fetch_pc - AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      count    <= '0;
      valid_q  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        instr_q[k] <= '0;
        pc_q[k]    <= '0;
      end
      req_q    <= 1'b0;
      addr_q   <= '0;
      halted_q <= 1'b0;
    end else if (state != S_HALTED) begin
      if (halt_i) begin
        state    <= S_HALTED;
        valid_q  <= '0;
        count    <= '0;
        req_q    <= 1'b0;
        halted_q <= 1'b1;
      end else if (jump_en_i) begin
        valid_q  <= '0;
        count    <= '0;
        fetch_pc <= jump_addr_i;
        addr_q   <= jump_addr_i;
        // A request still in flight after this edge must have its answer discarded.
        if (fire || (state != S_REQ && !mem.mem_rvalid)) begin
          state <= S_DROP;
          req_q <= 1'b0;
        end else begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
      end else begin
        valid_q <= n_valid;
        instr_q <= n_instr;
        pc_q    <= n_pc;
        count   <= n_count;
        addr_q  <= fetch_pc;
        case (state)
          S_REQ: begin
            if (fire) begin
              fetch_pc <= fetch_pc + AW'(1);
              state    <= S_WAIT;
              req_q    <= 1'b0;
            end else begin
              req_q <= (kept < DEPTH_C);
            end
          end
          S_WAIT, S_DROP: begin
            if (mem.mem_rvalid) begin
              state <= S_REQ;
              req_q <= (n_count < DEPTH_C);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign slot_valid_o = valid_q;
  assign halted_o     = halted_q;
  assign state_o      = state;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign slot_instr_o[g*DW +: DW] = instr_q[g];
    assign slot_pc_o[g*AW +: AW]    = pc_q[g];
  end

  retire_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    (state == S_HALTED) || (retire_cnt_i <= count));
endmodule
